// File: rtl/pythag_leg_solver.sv
// pythag_leg_solver
//   Computes the missing leg of a right triangle, floor(sqrt(c^2 - a^2)),
//   from the hypotenuse c_in and one leg a_in. The square difference is
//   formed in a single LOAD cycle. A restoring digit-by-digit square root then
//   consumes two bits of the difference per ITER cycle, so the latency is
//   fixed at 10 cycles from the start cycle to done.
//
// Handshake: start is sampled only in IDLE and latches the operands on that
//   edge. busy is high in LOAD and ITER. done pulses for exactly one cycle in
//   DONE, and busy is never high in that cycle. leg_out and err become valid
//   with done and hold until the next result or reset. A start seen outside
//   IDLE is dropped; nothing is queued.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset; aborts any operation
//   start   in   request pulse
//   c_in    in   W   hypotenuse (unsigned)
//   a_in    in   W   known leg (unsigned)
//   busy    out  1   operation in flight (LOAD/ITER)
//   done    out  1   one-cycle completion pulse
//   leg_out out  W   resulting leg, registered
//   err     out  1   a_in > c_in for the completed operation, registered
module pythag_leg_solver #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] c_in,
   input  logic [W-1:0] a_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] leg_out,
   output logic         err
);

   localparam int REM_W = (2 * W - 4 < 12) ? 12 : 2 * W - 4;
   localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [W-1:0]     c_q;
   logic [W-1:0]     a_q;
   logic [2*W-1:0]   d_q;
   logic [REM_W-1:0] rem_q;
   logic [W-1:0]     root_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_pend_q;

   // Squares are taken at full 2W width so c^2 - a^2 never truncates.
   logic [2*W-1:0] c_sq;
   logic [2*W-1:0] a_sq;
   assign c_sq = {{W{1'b0}}, c_q} * {{W{1'b0}}, c_q};
   assign a_sq = {{W{1'b0}}, a_q} * {{W{1'b0}}, a_q};

   // One restoring square-root step: bring down the next bit pair of d,
   // try subtracting (4*root + 1), and shift the outcome into root.
   logic [1:0]       pair;
   logic [REM_W-1:0] rem_shift;
   logic [REM_W-1:0] trial;
   logic             take;
   logic [REM_W-1:0] rem_nxt;
   logic [W-1:0]     root_nxt;
   logic             last_iter;

   assign pair      = d_q[{cnt_q, 1'b0} +: 2];
   assign rem_shift = {rem_q[REM_W-3:0], pair};
   assign trial     = {{(REM_W - W - 2){1'b0}}, root_q, 2'b01};
   assign take      = (rem_shift >= trial);
   assign rem_nxt   = take ? (rem_shift - trial) : rem_shift;
   assign root_nxt  = {root_q[W-2:0], take};
   assign last_iter = (cnt_q == '0);

   // The remainder never exceeds 2*root, so its top two bits stay zero and
   // are dropped by the shift above.
   logic unused_rem_hi;
   assign unused_rem_hi = ^rem_q[REM_W-1:REM_W-2];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_ITER;
         S_ITER:  if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_LOAD) || (state == S_ITER);
   assign done = (state == S_DONE);

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q        <= '0;
         a_q        <= '0;
         d_q        <= '0;
         rem_q      <= '0;
         root_q     <= '0;
         cnt_q      <= '0;
         err_pend_q <= 1'b0;
         leg_out    <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  c_q <= c_in;
                  a_q <= a_in;
               end
            end
            S_LOAD: begin
               // a > c has no real answer: run the root on zero and flag it.
               if (a_q > c_q) begin
                  d_q        <= '0;
                  err_pend_q <= 1'b1;
               end else begin
                  d_q        <= c_sq - a_sq;
                  err_pend_q <= 1'b0;
               end
               rem_q  <= '0;
               root_q <= '0;
               cnt_q  <= CNT_W'(W - 1);
            end
            S_ITER: begin
               rem_q  <= rem_nxt;
               root_q <= root_nxt;
               cnt_q  <= cnt_q - 1'b1;
               // Publish on the edge that enters DONE so the result is
               // valid in the same cycle as the done pulse.
               if (last_iter) begin
                  leg_out <= root_nxt;
                  err     <= err_pend_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Self-checking bench for pythag_leg_solver: reset, a vector table of known
// triangles, multi-cycle corner sequences (start while busy, reset mid-op,
// start held high), and randomized operands scored against an arithmetic
// reference model.
module tb_pythag_leg_solver;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] c_in;
   logic [W-1:0] a_in;
   logic         busy;
   logic         done;
   logic [W-1:0] leg_out;
   logic         err;

   always #5 clk = ~clk;

   pythag_leg_solver #(.W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .c_in    (c_in),
      .a_in    (a_in),
      .busy    (busy),
      .done    (done),
      .leg_out (leg_out),
      .err     (err)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Scoreboard: expected {err, leg} per accepted start, in order.
   logic [W:0] exp_q[$];

   // ---------------- reference model ----------------
   function automatic logic [W:0] ref_model(int c, int a);
      int d;
      int r;
      if (a > c) return {1'b1, {W{1'b0}}};
      d = c * c - a * a;
      r = 0;
      while ((r + 1) * (r + 1) <= d) r++;
      return {1'b0, W'(r)};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Presents start for one cycle (cycle C). Returns at #1 after the latching
   // edge, i.e. inside cycle C+1, with operands scrambled.
   task automatic apply_start(int c, int a);
      @(negedge clk);
      start = 1'b1;
      c_in  = W'(c);
      a_in  = W'(a);
      exp_q.push_back(ref_model(c, a));
      @(posedge clk);
      #1;
      start = 1'b0;
      c_in  = W'($urandom);
      a_in  = W'($urandom);
   endtask

   // Called inside cycle C+1. Checks busy/done during C+1..C+9, the done
   // pulse and result in C+10, and the held result in C+11. If poke_at > 0,
   // a start with operands (pc, pa) is presented during cycle C+poke_at.
   task automatic wait_done(string name, int poke_at, int pc, int pa);
      int         bad_cycles;
      logic [W:0] want;
      bad_cycles = 0;
      for (int k = 1; k <= 9; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad_cycles++;
         if (k == poke_at) begin
            start = 1'b1;
            c_in  = W'(pc);
            a_in  = W'(pa);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk({name, " busy window"}, bad_cycles, 0);
      chk({name, " done at +10"}, {30'd0, busy, done}, 32'd1);
      if (exp_q.size() == 0) begin
         chk({name, " scoreboard empty"}, 32'd0, 32'd1);
         want = '0;
      end else begin
         want = exp_q.pop_front();
      end
      chk({name, " result"}, {23'd0, err, leg_out}, {23'd0, want});
      @(posedge clk);
      #1;
      chk({name, " held"}, {22'd0, done, err, leg_out}, {22'd0, 1'b0, want});
   endtask

   typedef struct {
      int         c;
      int         a;
      logic [W:0] want;  // {err, leg}
      string      name;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int done_seen;
      int bad_cycles;

      vecs[0]  = '{5,   3,   {1'b0, 8'd4},   "v5_3"};
      vecs[1]  = '{25,  7,   {1'b0, 8'd24},  "v25_7"};
      vecs[2]  = '{17,  8,   {1'b0, 8'd15},  "v17_8"};
      vecs[3]  = '{10,  3,   {1'b0, 8'd9},   "v10_3"};
      vecs[4]  = '{255, 0,   {1'b0, 8'd255}, "v255_0"};
      vecs[5]  = '{10,  10,  {1'b0, 8'd0},   "v10_10"};
      vecs[6]  = '{3,   8,   {1'b1, 8'd0},   "v3_8_err"};
      vecs[7]  = '{5,   4,   {1'b0, 8'd3},   "v5_4_after_err"};
      vecs[8]  = '{0,   0,   {1'b0, 8'd0},   "v0_0"};
      vecs[9]  = '{255, 255, {1'b0, 8'd0},   "v255_255"};
      vecs[10] = '{0,   1,   {1'b1, 8'd0},   "v0_1_err"};
      vecs[11] = '{200, 0,   {1'b0, 8'd200}, "v200_0"};

      rst   = 1'b1;
      start = 1'b0;
      c_in  = '0;
      a_in  = '0;

      // Reset
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset outputs", {21'd0, busy, done, err, leg_out}, 32'd0);
      rst = 1'b0;

      // Vector table
      for (int i = 0; i < 12; i++) begin
         apply_start(vecs[i].c, vecs[i].a);
         exp_q.pop_back();
         exp_q.push_back(vecs[i].want);
         wait_done(vecs[i].name, 0, 0, 0);
      end

      // Start while busy: second request at C+4 must be dropped.
      apply_start(25, 7);
      wait_done("busy_ignore", 4, 13, 5);
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1) done_seen++;
         @(posedge clk);
         #1;
      end
      chk("busy_ignore no extra done", done_seen, 0);

      // Reset mid-operation, during cycle C+5.
      apply_start(17, 8);
      for (int k = 1; k < 5; k++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      chk("midreset outputs", {21'd0, busy, done, err, leg_out}, 32'd0);
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1) done_seen++;
         @(posedge clk);
         #1;
      end
      chk("midreset no done", done_seen, 0);
      apply_start(10, 6);
      wait_done("after_midreset", 0, 0, 0);

      // Start held high: back-to-back operations every 11 cycles.
      @(negedge clk);
      start = 1'b1;
      c_in  = 8'd25;
      a_in  = 8'd24;
      bad_cycles = 0;
      for (int k = 1; k <= 22; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) begin
            chk("held_start first", {23'd0, err, leg_out}, 32'd7);
            c_in = 8'd13;
            a_in = 8'd12;
         end
         if (k == 12) start = 1'b0;
         if (k == 21) chk("held_start second", {23'd0, err, leg_out}, 32'd5);
         if (done !== ((k == 10) || (k == 21))) bad_cycles++;
      end
      chk("held_start done spacing", bad_cycles, 0);

      // Randomized operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         int c;
         int a;
         c = $urandom_range(0, 255);
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
         else a = $urandom_range(0, c);
         apply_start(c, a);
         wait_done($sformatf("rand%0d_c%0d_a%0d", i, c, a), 0, 0, 0);
      end

      // Sweep a for the largest hypotenuse.
      for (int a = 0; a < 256; a += 5) begin
         apply_start(255, a);
         wait_done($sformatf("sweep_c255_a%0d", a), 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
